// File: rtl/cpu_register_file.sv
// Single CPU datapath register: captures dat_in on a rising clk_cpu when load is high,
// and clears asynchronously while the active-low reset is held.
module cpu_register_file #(
  parameter int unsigned           WIDTH       = 4,
  parameter logic [WIDTH-1:0]      RESET_VALUE = '0
) (
  input  logic             clk_cpu,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] dat_in,
  output logic [WIDTH-1:0] dat_out
);

  logic [WIDTH-1:0] value_q;

  // Reset dominates any edge it overlaps, so a pending load is dropped.
  always_ff @(posedge clk_cpu or negedge reset) begin
    if (!reset) begin
      value_q <= RESET_VALUE;
    end else if (load) begin
      value_q <= dat_in;
    end
  end

  assign dat_out = value_q;

endmodule

// File: tb/tb_cpu_register_file.sv
// Self-checking bench for cpu_register_file: expected values are queued when stimulus
// is driven and popped when dat_out is sampled just after the relevant edge.
module tb_cpu_register_file;

  localparam int W = 4;

  logic         clk_cpu;
  logic         reset;
  logic         load;
  logic [W-1:0] dat_in;
  logic [W-1:0] dat_out;

  logic [W-1:0] exp_q[$];
  int           n_cmp;
  int           n_err;
  logic [W-1:0] model;
  logic [W-1:0] val;

  cpu_register_file #(.WIDTH(W), .RESET_VALUE('0)) dut (
    .clk_cpu (clk_cpu),
    .reset   (reset),
    .load    (load),
    .dat_in  (dat_in),
    .dat_out (dat_out)
  );

  // Clock and watchdog
  initial begin
    clk_cpu = 1'b0;
    forever #5 clk_cpu = ~clk_cpu;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "simulation timeout");
  end

  task automatic check_eq(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic expect_val(input logic [W-1:0] v);
    exp_q.push_back(v);
  endtask

  task automatic sample(input string tag);
    logic [W-1:0] e;
    if (exp_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL %s: got empty scoreboard expected entry", tag);
    end else begin
      e = exp_q.pop_front();
      check_eq(tag, dat_out, e);
    end
  endtask

  // Drive a one-cycle load on a falling edge, check after the next falling edge.
  task automatic do_load(input string tag, input logic [W-1:0] v);
    @(negedge clk_cpu);
    load   = 1'b1;
    dat_in = v;
    expect_val(v);
    @(negedge clk_cpu);
    load = 1'b0;
    #1;
    sample(tag);
  endtask

  initial begin
    n_cmp  = 0;
    n_err  = 0;
    reset  = 1'b0;
    load   = 1'b0;
    dat_in = '0;

    // Reset state
    repeat (2) @(posedge clk_cpu);
    #1;
    expect_val(4'h0);
    sample("reset_init");
    @(negedge clk_cpu);
    reset = 1'b1;

    // Reset held for 5 cycles after a prior load of A
    do_load("pre_reset_load", 4'hA);
    @(negedge clk_cpu);
    reset = 1'b0;
    #1;
    expect_val(4'h0);
    sample("reset_async_clear");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_cpu);
      #1;
      expect_val(4'h0);
      sample("reset_hold");
    end
    @(negedge clk_cpu);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_cpu);
      #1;
      expect_val(4'h0);
      sample("reset_release_noload");
    end

    // Single load then sequential loads with 4-bit wrap: 1..15,0..4
    val = 4'h1;
    for (int i = 0; i < 20; i++) begin
      do_load(i == 0 ? "single_load" : "seq_wrap_load", val);
      val = val + 4'h1;
    end

    // Hold with changing dat_in
    do_load("hold_setup", 4'h7);
    @(negedge clk_cpu);
    dat_in = 4'h3;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk_cpu);
      #1;
      expect_val(4'h7);
      sample("hold");
    end

    // Async reset mid-cycle with a pending load
    do_load("async_setup", 4'hF);
    @(negedge clk_cpu);
    load   = 1'b1;
    dat_in = 4'h5;
    #2;
    reset = 1'b0;
    #1;
    expect_val(4'h0);
    sample("async_midcycle");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk_cpu);
      #1;
      expect_val(4'h0);
      sample("async_stay_low");
    end

    // Load during reset, then release with load still high
    @(negedge clk_cpu);
    dat_in = 4'h9;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_cpu);
      #1;
      expect_val(4'h0);
      sample("load_during_reset");
    end
    @(negedge clk_cpu);
    reset = 1'b1;
    expect_val(4'h9);
    @(posedge clk_cpu);
    #1;
    sample("first_load_after_release");
    @(negedge clk_cpu);
    load = 1'b0;

    // Random load/data with an independent behavioural model
    model = 4'h9;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk_cpu);
      load   = ($urandom_range(0, 2) != 0);
      dat_in = W'($urandom_range(0, 15));
      if (load) model = dat_in;
      expect_val(model);
      @(posedge clk_cpu);
      #1;
      sample("random");
    end
    @(negedge clk_cpu);
    load = 1'b0;

    if (exp_q.size() != 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL scoreboard_drain: got %0d leftover expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
